// File: rtl/proc_pkg.sv
// Shared processor definitions: architecture width, ROB sizing, opcodes and
// the decoded-instruction record passed from the decoder to dispatch.
package proc;

  localparam int ARCH_BITS    = 32;
  localparam int NUM_REGS     = 32;
  localparam int ROB_ENTRIES  = 8;
  localparam int ROB_IDX_BITS = 3;

  // Instruction layout: opcode[31:26] dst[25:21] src1[20:16] src2[15:11] imm[10:0]
  localparam logic [5:0] OPCODE_NOP      = 6'd0;
  localparam logic [5:0] OPCODE_ADD      = 6'd1;
  localparam logic [5:0] OPCODE_SUB      = 6'd2;
  localparam logic [5:0] OPCODE_MOVI     = 6'd3;
  localparam logic [5:0] OPCODE_LDW      = 6'd4;
  localparam logic [5:0] OPCODE_STB      = 6'd5;
  localparam logic [5:0] OPCODE_STW      = 6'd6;
  localparam logic [5:0] OPCODE_TLBWRITE = 6'd7;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] dst;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       enableSrc1;
    logic       enableSrc2;
    logic       assignRobIdx;
  } decode_t;

  // Stores and TLB writes take a ROB slot but produce no register result.
  function automatic logic writes_dst(input decode_t d);
    return d.assignRobIdx &&
           !(d.opcode inside {OPCODE_STB, OPCODE_STW, OPCODE_TLBWRITE});
  endfunction

endpackage

// File: rtl/dispatch_ctrl_decoder.sv
// Field extraction and operand/ROB usage per opcode. Unknown opcodes behave
// like NOP: no sources, no ROB slot.
module decoder
  import proc::*;
(
  input  logic [ARCH_BITS-1:0] inst,
  output decode_t              dec
);

  // Immediate bits are consumed downstream of issue, not here.
  logic unused_imm;
  assign unused_imm = ^inst[10:0];

  // Decode register fields and per-opcode enables.
  always_comb begin
    dec        = '0;
    dec.opcode = inst[31:26];
    dec.dst    = inst[25:21];
    dec.src1   = inst[20:16];
    dec.src2   = inst[15:11];
    case (inst[31:26])
      OPCODE_ADD, OPCODE_SUB, OPCODE_STB, OPCODE_STW: begin
        dec.enableSrc1   = 1'b1;
        dec.enableSrc2   = 1'b1;
        dec.assignRobIdx = 1'b1;
      end
      OPCODE_LDW, OPCODE_TLBWRITE: begin
        dec.enableSrc1   = 1'b1;
        dec.assignRobIdx = 1'b1;
      end
      OPCODE_MOVI: begin
        dec.assignRobIdx = 1'b1;
      end
      default: begin
        dec.assignRobIdx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch stage: scoreboard hazard check, ROB slot allocation and a single
// output register toward issue with valid/ready flow control.
module dispatch_ctrl #(
  parameter int ROB_ENTRIES  = proc::ROB_ENTRIES,
  parameter int ROB_IDX_BITS = proc::ROB_IDX_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [proc::ARCH_BITS-1:0] in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [proc::ARCH_BITS-1:0] out_inst,
  output logic [ROB_IDX_BITS-1:0]    out_robIdx,
  output logic                       out_hasRob,
  input  logic                       commit_valid,
  input  logic [ROB_IDX_BITS-1:0]    commit_robIdx,
  input  logic [4:0]                 commit_dst,
  input  logic                       flush,
  output logic                       robFull
);

  import proc::*;

  localparam int CNT_W = ROB_IDX_BITS + 1;

  decode_t                 dec;
  logic [NUM_REGS-1:0]     busy;
  logic [ROB_IDX_BITS-1:0] tag [NUM_REGS];
  logic [ROB_IDX_BITS-1:0] tail;
  logic [CNT_W-1:0]        count;
  logic                    hazard;
  logic                    wr_dst;
  logic                    dispatch;
  logic                    alloc;
  logic                    commit_ok;

  decoder u_decoder (
    .inst (in_inst),
    .dec  (dec)
  );

  assign wr_dst    = writes_dst(dec);
  // Registered busy bits only: a commit this cycle unblocks next cycle.
  assign hazard    = (dec.enableSrc1 && busy[dec.src1]) ||
                     (dec.enableSrc2 && busy[dec.src2]);
  assign robFull   = (count == CNT_W'(ROB_ENTRIES));
  assign in_ready  = (!out_valid || out_ready) && !hazard &&
                     !(dec.assignRobIdx && robFull) && !flush;
  assign dispatch  = in_valid && in_ready;
  assign alloc     = dispatch && dec.assignRobIdx;
  assign commit_ok = commit_valid && (count != '0);

  // Dispatch register: load on dispatch, hold on stall, drain on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_robIdx <= '0;
      out_hasRob <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (dispatch) begin
      out_valid  <= 1'b1;
      out_inst   <= in_inst;
      out_robIdx <= dec.assignRobIdx ? tail : '0;
      out_hasRob <= dec.assignRobIdx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // ROB tail pointer and occupancy; allocate and retire in one cycle cancel.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        tail <= tail + 1'b1;
      end
      case ({alloc, commit_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scoreboard: retire clears only the newest producer; dispatch set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        tag[r] <= '0;
      end
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (commit_ok && (tag[commit_dst] == commit_robIdx)) begin
        busy[commit_dst] <= 1'b0;
      end
      if (dispatch && wr_dst) begin
        busy[dec.dst] <= 1'b1;
        tag[dec.dst]  <= tail;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;
  import proc::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [2:0]  out_robIdx;
  logic        out_hasRob;
  logic        commit_valid;
  logic [2:0]  commit_robIdx;
  logic [4:0]  commit_dst;
  logic        flush;
  logic        robFull;

  int n_cmp = 0;
  int n_err = 0;

  dispatch_ctrl #(.ROB_ENTRIES(8), .ROB_IDX_BITS(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_inst       (in_inst),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_robIdx    (out_robIdx),
    .out_hasRob    (out_hasRob),
    .commit_valid  (commit_valid),
    .commit_robIdx (commit_robIdx),
    .commit_dst    (commit_dst),
    .flush         (flush),
    .robFull       (robFull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input int d, input int s1,
                                     input int s2, input int imm);
    return {op, 5'(d), 5'(s1), 5'(s2), 11'(imm)};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
    commit_valid = 1'b0; commit_robIdx = '0; commit_dst = '0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_hasRob", out_hasRob, 0);
    chk("rst_out_robIdx", out_robIdx, 0);
    chk("rst_robFull", robFull, 0);
    chk("rst_count", dut.count, 0);
    chk("rst_in_ready", in_ready, 1);

    // ADD r3,r1,r2 on an empty scoreboard
    in_valid = 1'b1; in_inst = mk(OPCODE_ADD, 3, 1, 2, 0); #1;
    chk("add_in_ready", in_ready, 1);
    tick();
    chk("add_out_valid", out_valid, 1);
    chk("add_out_inst", out_inst, mk(OPCODE_ADD, 3, 1, 2, 0));
    chk("add_robIdx", out_robIdx, 0);
    chk("add_hasRob", out_hasRob, 1);
    chk("add_busy3", dut.busy[3], 1);
    chk("add_count", dut.count, 1);

    // SUB r4,r3,r1 stalls on r3 until it retires
    in_inst = mk(OPCODE_SUB, 4, 3, 1, 0); #1;
    chk("sub_stall0", in_ready, 0);
    tick();
    chk("sub_drain_out_valid", out_valid, 0);
    chk("sub_stall1", in_ready, 0);
    commit_valid = 1'b1; commit_robIdx = 3'd0; commit_dst = 5'd3; #1;
    chk("sub_no_bypass", in_ready, 0);
    tick();
    commit_valid = 1'b0; #1;
    chk("sub_busy3_clr", dut.busy[3], 0);
    chk("sub_count0", dut.count, 0);
    chk("sub_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("sub_out_inst", out_inst, mk(OPCODE_SUB, 4, 3, 1, 0));
    chk("sub_robIdx", out_robIdx, 1);
    chk("sub_busy4", dut.busy[4], 1);
    chk("sub_count1", dut.count, 1);

    // Fill the ROB with MOVIs from a fresh reset, ninth waits, then wraps
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("fill_count0", dut.count, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_inst = mk(OPCODE_MOVI, 8 + i, 0, 0, i);
      tick();
      chk($sformatf("fill_robIdx%0d", i), out_robIdx, i);
    end
    chk("fill_robFull", robFull, 1);
    chk("fill_count8", dut.count, 8);
    in_inst = mk(OPCODE_MOVI, 20, 0, 0, 9); #1;
    chk("fill_9th_blocked", in_ready, 0);
    tick();
    chk("fill_9th_out_valid", out_valid, 0);
    chk("fill_9th_still_blocked", in_ready, 0);
    commit_valid = 1'b1; commit_robIdx = 3'd0; commit_dst = 5'd8;
    tick();
    commit_valid = 1'b0; #1;
    chk("fill_count7", dut.count, 7);
    chk("fill_busy8_clr", dut.busy[8], 0);
    chk("fill_9th_ready", in_ready, 1);
    tick();
    chk("wrap_out_valid", out_valid, 1);
    chk("wrap_out_inst", out_inst, mk(OPCODE_MOVI, 20, 0, 0, 9));
    chk("wrap_robIdx", out_robIdx, 0);
    chk("wrap_robFull", robFull, 1);

    // NOP needs no slot while full; then hold it for five cycles
    in_inst = mk(OPCODE_NOP, 0, 0, 0, 'h55); #1;
    chk("nop_ready_when_full", in_ready, 1);
    tick();
    chk("nop_hasRob", out_hasRob, 0);
    chk("nop_robIdx", out_robIdx, 0);
    chk("nop_count", dut.count, 8);
    out_ready = 1'b0; in_inst = mk(OPCODE_NOP, 0, 0, 0, 'hAA);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_in_ready", in_ready, 0);
      tick();
      chk("hold_out_inst", out_inst, mk(OPCODE_NOP, 0, 0, 0, 'h55));
      chk("hold_out_valid", out_valid, 1);
    end

    // Reset while stalled drops the held instruction and every slot
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_inst", out_inst, 0);
    chk("midrst_count", dut.count, 0);
    chk("midrst_robFull", robFull, 0);
    chk("midrst_busy20", dut.busy[20], 0);

    // Flush with five in flight, commit and dispatch that cycle discarded
    for (int r = 3; r <= 7; r++) begin
      in_valid = 1'b1; in_inst = mk(OPCODE_MOVI, r, 0, 0, r);
      tick();
    end
    out_ready = 1'b0;
    chk("preflush_count", dut.count, 5);
    chk("preflush_busy7", dut.busy[7], 1);
    flush = 1'b1; commit_valid = 1'b1; commit_robIdx = 3'd0; commit_dst = 5'd3;
    in_inst = mk(OPCODE_MOVI, 9, 0, 0, 1); #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; commit_valid = 1'b0; #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_count", dut.count, 0);
    chk("flush_busy7", dut.busy[7], 0);
    chk("flush_robFull", robFull, 0);
    chk("flush_in_ready_after", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("postflush_robIdx", out_robIdx, 0);
    chk("postflush_inst", out_inst, mk(OPCODE_MOVI, 9, 0, 0, 1));
    chk("postflush_count", dut.count, 1);

    // WAW on r5: only the newest producer's retire clears busy
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; in_inst = mk(OPCODE_MOVI, 5, 0, 0, 1);
    tick();
    in_inst = mk(OPCODE_MOVI, 5, 0, 0, 2);
    tick();
    in_valid = 1'b0;
    chk("waw_robIdx", out_robIdx, 1);
    commit_valid = 1'b1; commit_robIdx = 3'd0; commit_dst = 5'd5;
    tick();
    chk("waw_old_commit_busy5", dut.busy[5], 1);
    chk("waw_count1", dut.count, 1);
    commit_robIdx = 3'd1;
    tick();
    chk("waw_new_commit_busy5", dut.busy[5], 0);
    chk("waw_count0", dut.count, 0);
    commit_robIdx = 3'd0;
    tick();
    commit_valid = 1'b0;
    chk("commit_empty_ignored", dut.count, 0);

    // Same-cycle commit and dispatch to r6: count steady, dispatch wins
    in_valid = 1'b1; in_inst = mk(OPCODE_MOVI, 6, 0, 0, 3);
    tick();
    chk("same_first_robIdx", out_robIdx, 2);
    commit_valid = 1'b1; commit_robIdx = 3'd2; commit_dst = 5'd6;
    in_inst = mk(OPCODE_MOVI, 6, 0, 0, 4);
    tick();
    commit_valid = 1'b0;
    chk("same_count", dut.count, 1);
    chk("same_busy6", dut.busy[6], 1);
    chk("same_robIdx", out_robIdx, 3);

    // Store takes a slot but marks no destination busy
    in_inst = mk(OPCODE_STW, 10, 1, 2, 0);
    tick();
    in_valid = 1'b0;
    chk("stw_count", dut.count, 2);
    chk("stw_busy10", dut.busy[10], 0);
    chk("stw_hasRob", out_hasRob, 1);
    chk("stw_robIdx", out_robIdx, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameter ROB_ENTRIES, default 8, is the ROB depth (power of two, 2..32).
REQ-002 Parameter ROB_IDX_BITS, default 3, equals log2(ROB_ENTRIES).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  fetch stage offers an instruction.
REQ-006 in_inst  input  proc.ARCH_BITS  instruction word.
REQ-007 in_ready  output  1  dispatch_ctrl accepts in_inst this cycle.
REQ-008 out_valid  output  1  dispatch register holds an instruction.
REQ-009 out_ready  input  1  issue stage consumes the dispatch register.
REQ-010 out_inst  output  proc.ARCH_BITS  registered instruction word.
REQ-011 out_robIdx  output  ROB_IDX_BITS  ROB slot allocated to out_inst; 0 when out_hasRob=0.
REQ-012 out_hasRob  output  1  out_inst owns a ROB slot.
REQ-013 commit_valid  input  1  ROB retires its head entry this cycle.
REQ-014 commit_robIdx  input  ROB_IDX_BITS  ROB index being retired.
REQ-015 commit_dst  input  5  destination register of the retired entry.
REQ-016 flush  input  1  pipeline flush (mispredict/exception).
REQ-017 robFull  output  1  all ROB_ENTRIES slots are allocated.

Function
REQ-018 Decode fields (opcode, dst, src1, src2, enableSrc1, enableSrc2, assignRobIdx) shall come from an internal decoder instance fed by in_inst.
REQ-019 writesDst shall be assignRobIdx AND opcode not in {OPCODE_STB, OPCODE_STW, OPCODE_TLBWRITE}.
REQ-020 A 32-entry scoreboard shall hold busy[r] and tag[r] (ROB_IDX_BITS) per architectural register.
REQ-021 hazard shall be (enableSrc1 AND busy[src1]) OR (enableSrc2 AND busy[src2]), using registered busy bits with no same-cycle commit bypass.
REQ-022 in_ready shall be (!out_valid OR out_ready) AND !hazard AND !(assignRobIdx AND robFull) AND !flush.
REQ-023 Dispatch occurs when in_valid AND in_ready; the instruction appears on out_* the next cycle (latency 1).
REQ-024 On dispatch with assignRobIdx=1: out_robIdx<=tail, out_hasRob<=1, tail<=tail+1 modulo ROB_ENTRIES, count increments.
REQ-025 On dispatch with writesDst=1: busy[dst]<=1, tag[dst]<=allocated index, overwriting any earlier producer (WAW permitted).
REQ-026 out_valid AND !out_ready shall hold out_* stable; out_valid AND out_ready with no dispatch shall clear out_valid.
REQ-027 commit_valid with count>0 shall decrement count and clear busy[commit_dst] only if tag[commit_dst]==commit_robIdx; commit_valid with count==0 is ignored.
REQ-028 Simultaneous dispatch and commit: count unchanged; if both target one register, the dispatch set/tag wins.
REQ-029 robFull shall be count==ROB_ENTRIES; count width ROB_IDX_BITS+1.
REQ-030 flush shall, next cycle, clear out_valid, all busy bits, count and tail; in-flight commit and dispatch that cycle are discarded.
REQ-031 in_valid low or in_inst changing while in_ready=0 shall have no side effects.

Reset
REQ-032 rst shall set out_valid=0, out_inst=0, out_robIdx=0, out_hasRob=0, tail=0, count=0, all busy=0, all tag=0; rst takes priority over flush and all handshakes.
REQ-033 rst asserted mid-stall shall drop the held instruction with no allocation leaked.

Structure
REQ-034 ROB_ENTRIES default, ROB_IDX_BITS and all OPCODE_* constants belong in package proc alongside ARCH_BITS.
REQ-035 The single sub-module shall be decoder; scoreboard and ROB counters stay inline.

Verification
REQ-036 ADD r3,r1,r2 with empty scoreboard -> out_valid next cycle, out_robIdx=0, busy[3]=1, count=1.
REQ-037 ADD r3 then SUB r4,r3,r1 back-to-back -> SUB stalls (in_ready=0) until commit_valid, commit_robIdx=0, commit_dst=3, then dispatches one cycle later with out_robIdx=1.
REQ-038 9 MOVI dispatches, no commits, ROB_ENTRIES=8 -> robFull=1 after 8th, 9th held; one commit -> 9th dispatches with out_robIdx=0 (wrap).
REQ-039 out_ready=0 for 5 cycles with out_valid=1 -> out_inst/out_robIdx unchanged, in_ready=0.
REQ-040 flush with count=5, busy[7]=1 -> next cycle out_valid=0, count=0, busy[7]=0, robFull=0, next dispatch gets out_robIdx=0.
REQ-041 MOVI r5 (idx 0), MOVI r5 (idx 1), commit idx 0 dst 5 -> busy[5] stays 1; commit idx 1 -> busy[5]=0.
